inst_fetch_queue: RTL and testbench

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

---
 rtl/inst_fetch_queue.sv | 104 ++++++++++
 tb/tb_inst_fetch_queue.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// In-order instruction fetch queue: issues sequential fetches, holds pc/inst slots,
// and drops in-flight responses that belong to fetches squashed by a redirect.
module inst_fetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         fetch_en,
  input  logic                         redirect,
  input  logic [ADDR_W-1:0]            redirect_pc,
  output logic                         imem_req_valid,
  input  logic                         imem_req_ready,
  output logic [ADDR_W-1:0]            imem_req_addr,
  input  logic                         imem_resp_valid,
  input  logic [INST_W-1:0]            imem_resp_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [INST_W-1:0]            out_inst,
  output logic [ADDR_W-1:0]            out_pc,
  output logic [ADDR_W-1:0]            out_pc_next,
  output logic [$clog2(DEPTH+1)-1:0]   used
);
  localparam int                PW        = $clog2(DEPTH);
  localparam int                UW        = $clog2(DEPTH+1);
  localparam int                CW        = $clog2(2*DEPTH+1);
  localparam logic [UW-1:0]     DEPTH_U   = UW'(DEPTH);
  localparam logic [CW-1:0]     OUTST_MAX = CW'(2*DEPTH);
  localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(4);

  logic [DEPTH-1:0][ADDR_W-1:0] r_pc;
  logic [DEPTH-1:0][INST_W-1:0] r_inst;
  logic [DEPTH-1:0]             r_filled;
  logic [PW-1:0]                r_head, r_tail, r_fill;
  logic [UW-1:0]                r_used;
  logic [CW-1:0]                r_outst, r_drop;
  logic [ADDR_W-1:0]            r_fetch_pc;

  logic w_acc, w_pop, w_fill;

  // The outstanding cap only bites after back-to-back redirects with a stalled
  // memory; it keeps the in-flight counters inside their 2*DEPTH range.
  assign imem_req_valid = rst_n & fetch_en & ~redirect & (r_used < DEPTH_U) & (r_outst < OUTST_MAX);
  assign imem_req_addr  = r_fetch_pc;

  assign w_acc  = imem_req_valid & imem_req_ready;
  assign w_pop  = r_filled[r_head] & out_ready;
  assign w_fill = imem_resp_valid & (r_drop == '0) & ~redirect;

  assign out_valid   = r_filled[r_head];
  assign out_inst    = r_inst[r_head];
  assign out_pc      = r_pc[r_head];
  assign out_pc_next = r_pc[r_head] + STEP;
  assign used        = r_used;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]   <= RESET_PC;
        r_inst[i] <= '0;
      end
      r_filled   <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_fill     <= '0;
      r_used     <= '0;
      r_outst    <= '0;
      r_drop     <= '0;
      r_fetch_pc <= RESET_PC;
    end else begin
      r_outst    <= r_outst + CW'(w_acc) - CW'(imem_resp_valid);
      r_fetch_pc <= redirect ? redirect_pc : (w_acc ? r_fetch_pc + STEP : r_fetch_pc);
      if (redirect) begin
        // Everything still in flight after this cycle belongs to squashed fetches.
        r_drop   <= r_outst - CW'(imem_resp_valid);
        r_filled <= '0;
        r_head   <= '0;
        r_tail   <= '0;
        r_fill   <= '0;
        r_used   <= '0;
      end else begin
        if (imem_resp_valid && r_drop != '0)
          r_drop <= r_drop - CW'(1);
        if (w_acc) begin
          r_pc[r_tail] <= r_fetch_pc;
          r_tail       <= r_tail + PW'(1);
        end
        // Fill slot is always unfilled, head is filled when popping: never the same slot.
        if (w_fill) begin
          r_inst[r_fill]   <= imem_resp_data;
          r_filled[r_fill] <= 1'b1;
          r_fill           <= r_fill + PW'(1);
        end
        if (w_pop) begin
          r_filled[r_head] <= 1'b0;
          r_head           <= r_head + PW'(1);
        end
        r_used <= r_used + UW'(w_acc) - UW'(w_pop);
      end
    end
  end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: a latency/hold memory model feeds the DUT,
// expected pc/inst pushed on accept, popped on each out handshake.
module tb_inst_fetch_queue;
  localparam int AW = 32, IW = 32, D = 4;

  logic          clk = 0, rst_n = 1, fetch_en = 0, redirect = 0;
  logic          imem_req_ready = 0, imem_resp_valid = 0, out_ready = 0;
  logic [AW-1:0] redirect_pc = '0, imem_req_addr, out_pc, out_pc_next;
  logic [IW-1:0] imem_resp_data = '0, out_inst;
  logic          imem_req_valid, out_valid;
  logic [2:0]    used;

  always #5 clk = ~clk;

  inst_fetch_queue #(.ADDR_W(AW), .INST_W(IW), .DEPTH(D), .RESET_PC('0)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_pc(out_pc), .out_pc_next(out_pc_next), .used(used)
  );

  typedef struct { logic [AW-1:0] addr; int due; } mreq_t;

  int            n_chk = 0, n_err = 0, cyc = 0, n_acc = 0, n_hs = 0;
  int            mem_lat = 1;
  bit            mem_hold = 0;
  logic [AW-1:0] model_pc = '0;
  logic [AW-1:0] exp_q[$];
  mreq_t         mem_q[$];

  function automatic logic [IW-1:0] mem_data(input logic [AW-1:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_0000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Sample at negedge (inputs stable until next posedge), then drive memory #1 after posedge.
  task automatic tick();
    logic [AW-1:0] e, en;
    mreq_t m;
    @(negedge clk);
    if (out_valid && out_ready) begin
      n_hs++;
      chk("sb_nonempty", 64'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        en = e + 32'd4;
        chk("out_pc", out_pc, e);
        chk("out_pc_next", out_pc_next, en);
        chk("out_inst", out_inst, mem_data(e));
      end
    end
    if (redirect) begin
      exp_q.delete();
      model_pc = redirect_pc;
    end
    if (imem_req_valid && imem_req_ready) begin
      n_acc++;
      chk("req_addr", imem_req_addr, model_pc);
      exp_q.push_back(model_pc);
      mem_q.push_back('{addr: model_pc, due: cyc + mem_lat});
      model_pc += 32'd4;
    end
    @(posedge clk); #1;
    cyc++;
    if (!mem_hold && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      m = mem_q.pop_front();
      imem_resp_valid = 1;
      imem_resp_data  = mem_data(m.addr);
    end else begin
      imem_resp_valid = 0;
      imem_resp_data  = '0;
    end
  endtask

  task automatic do_reset();
    rst_n = 0; fetch_en = 0; redirect = 0; out_ready = 0; imem_req_ready = 1;
    imem_resp_valid = 0; mem_hold = 0; mem_lat = 1;
    exp_q.delete(); mem_q.delete(); model_pc = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic drain(input int n);
    out_ready = 1;
    repeat (n) tick();
    chk("sb_empty", exp_q.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values, with fetch_en high to prove the request is held off
    #1 rst_n = 0; fetch_en = 1; imem_req_ready = 1;
    #12;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_used", used, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_pc_next", out_pc_next, 4);
    chk("rst_out_inst", out_inst, 0);

    // streaming, one instruction per cycle
    do_reset();
    out_ready = 1; fetch_en = 1;
    repeat (4) tick();
    n_hs = 0;
    repeat (8) tick();
    chk("stream_rate", n_hs, 8);
    fetch_en = 0;
    drain(6);

    // fill to DEPTH, hold, pop one, refill
    do_reset();
    fetch_en = 1; out_ready = 0; n_acc = 0;
    repeat (10) tick();
    chk("full_accepts", n_acc, 4);
    chk("full_req_valid", imem_req_valid, 0);
    chk("full_used", used, 4);
    chk("full_out_valid", out_valid, 1);
    chk("hold_out_pc", out_pc, 0);
    out_ready = 1; tick(); out_ready = 0;
    chk("pop_used", used, 3);
    chk("pop_req_valid", imem_req_valid, 1);
    chk("pop_req_addr", imem_req_addr, 32'h10);
    n_acc = 0; tick();
    chk("refill_accepts", n_acc, 1);
    chk("refill_used", used, 4);
    fetch_en = 0;
    drain(10);

    // redirect with two fetches in flight
    do_reset();
    out_ready = 1; mem_hold = 1; fetch_en = 1;
    repeat (2) tick();
    fetch_en = 0; redirect = 1; redirect_pc = 32'h100;
    tick();
    redirect = 0;
    chk("rd_used", used, 0);
    chk("rd_out_valid", out_valid, 0);
    fetch_en = 1; tick(); fetch_en = 0;
    n_hs = 0; mem_hold = 0;
    repeat (8) tick();
    chk("rd_outputs", n_hs, 1);
    chk("sb_empty", exp_q.size(), 0);

    // redirect coinciding with a response and an out handshake
    do_reset();
    out_ready = 0; mem_hold = 1; fetch_en = 1;
    repeat (3) tick();
    fetch_en = 0; mem_hold = 0;
    repeat (2) tick();
    chk("rd2_pre_out_valid", out_valid, 1);
    chk("rd2_pre_resp", imem_resp_valid, 1);
    redirect = 1; redirect_pc = 32'h200; out_ready = 1; mem_hold = 1; n_hs = 0;
    tick();
    redirect = 0;
    chk("rd2_handshake", n_hs, 1);
    chk("rd2_used", used, 0);
    chk("rd2_out_valid", out_valid, 0);
    fetch_en = 1; tick(); fetch_en = 0;
    n_hs = 0; mem_hold = 0;
    repeat (8) tick();
    chk("rd2_outputs", n_hs, 1);
    chk("sb_empty", exp_q.size(), 0);

    // address wrap
    do_reset();
    redirect = 1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 0; out_ready = 1; fetch_en = 1; n_hs = 0;
    repeat (3) tick();
    fetch_en = 0;
    drain(6);
    chk("wrap_outputs", n_hs, 3);

    // async reset with three filled slots
    do_reset();
    out_ready = 0; fetch_en = 1;
    repeat (3) tick();
    fetch_en = 0;
    repeat (3) tick();
    chk("pre_rst_used", used, 3);
    chk("pre_rst_out_valid", out_valid, 1);
    fetch_en = 1;
    #2 rst_n = 0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_req_valid", imem_req_valid, 0);
    chk("arst_used", used, 0);
    chk("arst_out_pc", out_pc, 0);
    exp_q.delete(); mem_q.delete(); model_pc = '0; imem_resp_valid = 0;
    @(posedge clk); #1 rst_n = 1;
    n_acc = 0; out_ready = 1;
    tick();
    chk("restart_accepts", n_acc, 1);
    repeat (2) tick();
    fetch_en = 0;
    drain(6);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
